// File: rtl/acc_cpu_core_if.sv
// Instruction/result bundle between the pin-level wrapper (master) and the accumulator core (slave).
interface acc_cpu_core_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [DW-1:0] operand;
    logic [AW-1:0] addr;
    logic [DW-1:0] acc_out;
    logic          flag_z;
    logic          flag_c;
    logic          done;

    modport master (
        output instr_valid, opcode, operand, addr,
        input  instr_ready, acc_out, flag_z, flag_c, done
    );

    modport slave (
        input  instr_valid, opcode, operand, addr,
        output instr_ready, acc_out, flag_z, flag_c, done
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: DW-bit accumulator, 2**AW-word register memory, Z/C flags,
// single-issue instruction port; memory-read ops spend one extra cycle in MEM.
//
// state  | meaning
// IDLE   | ready for an instruction; done pulses here after a retire
// MEM    | registered read of mem[addr] into the data register
// EXEC   | accumulator, flags and memory updated at the closing edge
module acc_cpu_core #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_core_if.slave     bus
);
    localparam int DEPTH = 2 ** AW;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_LDI   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_EXEC
    } state_t;

    state_t        state_q;
    logic [3:0]    op_q;
    logic [DW-1:0] operand_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] acc_q;
    logic          z_q;
    logic          c_q;
    logic          done_q;
    logic          ready_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic [DW-1:0] acc_d;
    logic          z_d;
    logic          c_d;
    logic          acc_wr;
    logic          mem_wr;
    logic [DW:0]   sum_w;

    // Result of the latched instruction; only committed during EXEC.
    always_comb begin
        acc_d  = acc_q;
        c_d    = c_q;
        acc_wr = 1'b0;
        mem_wr = 1'b0;
        sum_w  = '0;
        case (op_q)
            OP_ADD: begin
                sum_w  = {1'b0, acc_q} + {1'b0, operand_q};
                acc_d  = sum_w[DW-1:0];
                c_d    = sum_w[DW];
                acc_wr = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                sum_w  = {1'b0, acc_q} - {1'b0, operand_q};
                acc_d  = sum_w[DW-1:0];
                c_d    = sum_w[DW];
                acc_wr = 1'b1;
            end
            OP_STORE: mem_wr = 1'b1;
            OP_LOAD: begin
                acc_d  = data_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_LDI: begin
                acc_d  = operand_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_AND: begin
                acc_d  = acc_q & operand_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_OR: begin
                acc_d  = acc_q | operand_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_XOR: begin
                acc_d  = acc_q ^ operand_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_NOT: begin
                acc_d  = ~acc_q;
                c_d    = 1'b0;
                acc_wr = 1'b1;
            end
            OP_SHL: begin
                acc_d  = {acc_q[DW-2:0], 1'b0};
                c_d    = acc_q[DW-1];
                acc_wr = 1'b1;
            end
            OP_SHR: begin
                acc_d  = {1'b0, acc_q[DW-1:1]};
                c_d    = acc_q[0];
                acc_wr = 1'b1;
            end
            OP_ADDM: begin
                sum_w  = {1'b0, acc_q} + {1'b0, data_q};
                acc_d  = sum_w[DW-1:0];
                c_d    = sum_w[DW];
                acc_wr = 1'b1;
            end
            default: begin
                acc_wr = 1'b0;
                mem_wr = 1'b0;
            end
        endcase
        z_d = (acc_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            operand_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            z_q       <= 1'b1;
            c_q       <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q      <= bus.opcode;
                        operand_q <= bus.operand;
                        addr_q    <= bus.addr;
                        ready_q   <= 1'b0;
                        if (bus.opcode == OP_LOAD || bus.opcode == OP_ADDM) begin
                            state_q <= S_MEM;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_MEM: begin
                    data_q  <= mem_q[addr_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (acc_wr) begin
                        acc_q <= acc_d;
                        z_q   <= z_d;
                        c_q   <= c_d;
                    end
                    if (mem_wr) begin
                        mem_q[addr_q] <= acc_q;
                    end
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.acc_out     = acc_q;
    assign bus.flag_z      = z_q;
    assign bus.flag_c      = c_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed instruction sequences, an architectural model checked
// every cycle, and literal expectations after each scenario.
module tb_acc_cpu_core;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int M  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc_cpu_core_if #(.DW(DW), .AW(AW)) bus ();
    acc_cpu_core #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: updated at accept time, visible values follow on each done.
    typedef struct {
        int acc;
        int z;
        int c;
        int lat;
        int t0;
    } exp_t;

    int   m_acc, m_z, m_c;
    int   m_mem [16];
    int   vis_acc, vis_z, vis_c;
    exp_t q [$];
    exp_t e;

    function automatic exp_t model_exec(input int op, input int b, input int ad);
        exp_t r;
        int   a   = m_acc;
        int   res = m_acc;
        int   cc  = m_c;
        int   wr  = 1;
        r.lat = 2;
        case (op)
            0:  begin res = a + b; cc = (res >= M); res = res % M; end
            1:  begin cc = (b > a); res = (a - b + M) % M; end
            2:  begin m_mem[ad] = a; wr = 0; end
            3:  begin res = m_mem[ad]; cc = 0; r.lat = 3; end
            4:  begin res = b; cc = 0; end
            5:  begin res = a & b; cc = 0; end
            6:  begin res = a | b; cc = 0; end
            7:  begin res = a ^ b; cc = 0; end
            8:  begin res = M - 1 - a; cc = 0; end
            9:  begin cc = (a >= M / 2); res = (a * 2) % M; end
            10: begin cc = a % 2; res = a / 2; end
            11: begin res = a + m_mem[ad]; cc = (res >= M); res = res % M; r.lat = 3; end
            default: wr = 0;
        endcase
        if (wr != 0) begin
            m_acc = res;
            m_c   = cc;
            m_z   = (res == 0) ? 1 : 0;
        end
        r.acc = m_acc;
        r.z   = m_z;
        r.c   = m_c;
        r.t0  = cyc;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_acc", int'(bus.acc_out), 0);
            chk("rst_z", int'(bus.flag_z), 1);
            chk("rst_c", int'(bus.flag_c), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_ready", int'(bus.instr_ready), 1);
            m_acc = 0; m_z = 1; m_c = 0;
            vis_acc = 0; vis_z = 1; vis_c = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 0;
            q.delete();
        end else begin
            chk("ready", int'(bus.instr_ready), (q.size() == 0 || bus.done) ? 1 : 0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    vis_acc = e.acc; vis_z = e.z; vis_c = e.c;
                    chk("latency", cyc - e.t0, e.lat);
                end
            end
            chk("acc", int'(bus.acc_out), vis_acc);
            chk("flag_z", int'(bus.flag_z), vis_z);
            chk("flag_c", int'(bus.flag_c), vis_c);
            if (bus.instr_valid && bus.instr_ready) begin
                q.push_back(model_exec(int'(bus.opcode), int'(bus.operand), int'(bus.addr)));
            end
        end
    end

    // Stimulus runs aligned to 2 time units after a rising edge.
    task automatic issue(input int op, input int opnd, input int ad);
        bit got = 0;
        bus.opcode      = op[3:0];
        bus.operand     = opnd[7:0];
        bus.addr        = ad[3:0];
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.instr_ready) got = 1;
            @(posedge clk);
            #2;
        end
        bus.instr_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int op, input int opnd, input int ad);
        issue(op, opnd, ad);
        wait_done();
    endtask

    task automatic lit(input string name, input int acc, input int z, input int c);
        chk({name, "_acc"}, int'(bus.acc_out), acc);
        chk({name, "_z"}, int'(bus.flag_z), z);
        chk({name, "_c"}, int'(bus.flag_c), c);
    endtask

    int s_op  [5] = '{4, 0, 2, 4, 11};
    int s_opd [5] = '{8'h10, 8'h20, 0, 8'h07, 0};
    int s_ad  [5] = '{0, 0, 5, 0, 5};

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.operand     = '0;
        bus.addr        = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        run(4, 8'hFF, 0); run(0, 8'h01, 0);
        lit("add_wrap", 8'h00, 1, 1);

        run(4, 8'h5A, 0); run(2, 0, 3); run(4, 8'h00, 0); run(3, 0, 3);
        lit("load", 8'h5A, 0, 0);

        run(4, 8'h03, 0); run(1, 8'h05, 0);
        lit("sub_borrow", 8'hFE, 0, 1);
        run(11, 0, 3);
        lit("addm", 8'h58, 0, 1);

        run(4, 8'h81, 0); run(9, 0, 0);
        lit("shl", 8'h02, 0, 1);
        run(4, 8'h01, 0); run(10, 0, 0);
        lit("shr", 8'h00, 1, 1);
        run(8, 0, 0);
        lit("not", 8'hFF, 0, 0);

        run(4, 8'hF0, 0); run(5, 8'h3C, 0);
        lit("and", 8'h30, 0, 0);
        run(6, 8'h0F, 0); run(7, 8'h3F, 0);
        lit("xor", 8'h00, 1, 0);
        run(12, 8'h12, 7);
        lit("nop", 8'h00, 1, 0);

        // Back-to-back stream with valid held high; fields scrambled whenever busy.
        begin
            int idx = 0;
            bit acc_now;
            bus.instr_valid = 1'b1;
            for (int k = 0; k < 200 && idx < 5; k++) begin
                if (bus.instr_ready) begin
                    bus.opcode  = s_op[idx][3:0];
                    bus.operand = s_opd[idx][7:0];
                    bus.addr    = s_ad[idx][3:0];
                end else begin
                    bus.opcode  = 4'($urandom_range(0, 15));
                    bus.operand = 8'($urandom_range(0, 255));
                    bus.addr    = 4'($urandom_range(0, 15));
                end
                @(negedge clk);
                acc_now = bus.instr_ready;
                @(posedge clk);
                #2;
                if (acc_now) idx++;
            end
            bus.instr_valid = 1'b0;
            chk("stream_accepted", idx, 5);
            wait_done();
            lit("stream", 8'h37, 0, 0);
        end

        // Reset while a LOAD sits in MEM: aborted, no done.
        issue(3, 0, 5);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        lit("abort", 8'h00, 1, 0);
        run(3, 0, 0);
        lit("load_after_rst", 8'h00, 1, 0);
        run(3, 0, 5);
        lit("mem_cleared", 8'h00, 1, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
